// File: rtl/mid_system.sv
// Three independent units behind one boundary: 4-bit add/sub (A), serial "1011"
// detector with wrap-around hit counter (B), and an 8-to-3 priority encoder (C).
module mid_system #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       a_x,
  input  logic [3:0]       a_y,
  input  logic             a_sub,
  output logic [3:0]       a_res,
  output logic             a_cout,
  output logic             a_ovf,
  input  logic             b_en,
  input  logic             b_din,
  output logic             b_det,
  output logic [CNT_W-1:0] b_cnt,
  input  logic [7:0]       c_in,
  output logic [2:0]       c_code,
  output logic             c_valid
);

  // Unit A: subtraction is X + ~Y + 1, so cout doubles as the no-borrow flag
  logic [3:0] a_yp;
  logic [4:0] a_sum;

  assign a_yp   = a_y ^ {4{a_sub}};
  assign a_sum  = {1'b0, a_x} + {1'b0, a_yp} + {4'b0000, a_sub};
  assign a_res  = a_sum[3:0];
  assign a_cout = a_sum[4];
  assign a_ovf  = (a_x[3] == a_yp[3]) && (a_sum[3] != a_x[3]);

  // Unit B: Moore detector, overlapping matches
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} b_state_t;

  b_state_t b_st;

  function automatic b_state_t b_next(input b_state_t s, input logic d);
    case (s)
      S0:      b_next = d ? S1 : S0;
      S1:      b_next = d ? S1 : S2;
      S2:      b_next = d ? S3 : S0;
      S3:      b_next = d ? S4 : S2;
      S4:      b_next = d ? S1 : S2;
      default: b_next = S0;
    endcase
  endfunction

  // det is registered alongside the state so it is high exactly while in S4
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_st  <= S0;
      b_det <= 1'b0;
      b_cnt <= '0;
    end else if (b_en) begin
      b_st  <= b_next(b_st, b_din);
      b_det <= (b_next(b_st, b_din) == S4);
      if (b_next(b_st, b_din) == S4)
        b_cnt <= b_cnt + 1'b1;
    end
  end

  // Unit C: later iterations overwrite, so the highest set bit wins
  always_comb begin
    c_code = 3'b000;
    for (int i = 0; i < 8; i++)
      if (c_in[i]) c_code = 3'(i);
  end

  assign c_valid = |c_in;

endmodule

// File: tb/tb_mid_system.sv
// Bench for mid_system: table vectors plus randomized checks against
// arithmetic / bit-history reference models for all three units.
module tb_mid_system;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [3:0]       a_x = '0, a_y = '0;
  logic             a_sub = 1'b0;
  logic [3:0]       a_res;
  logic             a_cout, a_ovf;
  logic             b_en = 1'b0, b_din = 1'b0;
  logic             b_det;
  logic [CNT_W-1:0] b_cnt;
  logic [7:0]       c_in = '0;
  logic [2:0]       c_code;
  logic             c_valid;

  int checks = 0;
  int errors = 0;

  // Unit B reference: history of sampled bits since reset
  logic [3:0] m_hist;
  int         m_nbits;
  int         m_det;
  int         m_cnt;

  mid_system #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .a_x(a_x), .a_y(a_y), .a_sub(a_sub),
    .a_res(a_res), .a_cout(a_cout), .a_ovf(a_ovf),
    .b_en(b_en), .b_din(b_din), .b_det(b_det), .b_cnt(b_cnt),
    .c_in(c_in), .c_code(c_code), .c_valid(c_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x, y;
    logic       sub;
    logic [3:0] res;
    logic       cout, ovf;
  } avec_t;

  typedef struct {
    logic [7:0] in;
    logic [2:0] code;
    logic       valid;
  } cvec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unit A reference from integer arithmetic on unsigned and signed views
  task automatic a_ref(input int x, input int y, input int sub,
                       output int res, output int cout, output int ovf);
    int sx, sy, sr;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    if (sub != 0) begin
      res  = (x - y + 16) % 16;
      cout = (x >= y) ? 1 : 0;
      sr   = sx - sy;
    end else begin
      res  = (x + y) % 16;
      cout = (x + y >= 16) ? 1 : 0;
      sr   = sx + sy;
    end
    ovf = (sr < -8 || sr > 7) ? 1 : 0;
  endtask

  function automatic int c_ref(input int v);
    for (int i = 7; i >= 0; i--)
      if (((v >> i) & 1) != 0) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_hist = 4'b0000; m_nbits = 0; m_det = 0; m_cnt = 0;
  endtask

  task automatic check_b(input string tag);
    chk({tag, " det"}, int'(b_det), m_det);
    chk({tag, " cnt"}, int'(b_cnt), m_cnt);
  endtask

  // Called at posedge+1; one clock with the given inputs, then compare
  task automatic bstep(input logic en, input logic din, input string tag);
    b_en = en; b_din = din;
    @(posedge clk); #1;
    if (en) begin
      m_hist = {m_hist[2:0], din};
      m_nbits++;
      m_det = (m_nbits >= 4 && m_hist == 4'b1011) ? 1 : 0;
      if (m_det != 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    check_b(tag);
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_b(tag);
    rstn = 1'b1;
  endtask

  task automatic send(input logic [6:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) bstep(1'b1, bits[i], tag);
  endtask

  avec_t av[4];
  cvec_t cv[4];

  initial begin
    int er, ec, eo, held_cnt;

    av[0] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    av[1] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    av[2] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    av[3] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    cv[0] = '{8'h00, 3'd0, 1'b0};
    cv[1] = '{8'h01, 3'd0, 1'b1};
    cv[2] = '{8'h24, 3'd5, 1'b1};
    cv[3] = '{8'hFF, 3'd7, 1'b1};

    // ---- Unit A ----
    for (int i = 0; i < 4; i++) begin
      a_x = av[i].x; a_y = av[i].y; a_sub = av[i].sub;
      #1;
      chk("a_tab res",  int'(a_res),  int'(av[i].res));
      chk("a_tab cout", int'(a_cout), int'(av[i].cout));
      chk("a_tab ovf",  int'(a_ovf),  int'(av[i].ovf));
    end
    for (int i = 0; i < 200; i++) begin
      a_x = 4'($urandom_range(0, 15));
      a_y = 4'($urandom_range(0, 15));
      a_sub = 1'($urandom_range(0, 1));
      #1;
      a_ref(int'(a_x), int'(a_y), int'(a_sub), er, ec, eo);
      chk("a_rnd res",  int'(a_res),  er);
      chk("a_rnd cout", int'(a_cout), ec);
      chk("a_rnd ovf",  int'(a_ovf),  eo);
    end

    // ---- Unit C ----
    for (int i = 0; i < 4; i++) begin
      c_in = cv[i].in;
      #1;
      chk("c_tab code",  int'(c_code),  int'(cv[i].code));
      chk("c_tab valid", int'(c_valid), int'(cv[i].valid));
    end
    for (int v = 0; v < 256; v++) begin
      c_in = 8'(v);
      #1;
      chk("c_swp code",  int'(c_code),  c_ref(v));
      chk("c_swp valid", int'(c_valid), (v != 0) ? 1 : 0);
    end

    // ---- Unit B ----
    model_reset();
    #1 check_b("b_reset_async");
    @(posedge clk); @(posedge clk); #1;
    check_b("b_reset_hold");
    rstn = 1'b1;

    // 1,0,1,1,0,1,1: hits after bits 4 and 7
    bstep(1'b1, 1'b1, "b_seq1"); chk("b_seq1 det1", int'(b_det), 0);
    bstep(1'b1, 1'b0, "b_seq2");
    bstep(1'b1, 1'b1, "b_seq3");
    bstep(1'b1, 1'b1, "b_seq4"); chk("b_seq4 det", int'(b_det), 1);
    bstep(1'b1, 1'b0, "b_seq5"); chk("b_seq5 det", int'(b_det), 0);
    bstep(1'b1, 1'b1, "b_seq6");
    bstep(1'b1, 1'b1, "b_seq7"); chk("b_seq7 det", int'(b_det), 1);
    chk("b_seq cnt2", int'(b_cnt), 2);

    // enable low: det/cnt frozen while din toggles
    held_cnt = int'(b_cnt);
    for (int i = 0; i < 6; i++) bstep(1'b0, 1'(i), "b_hold");
    chk("b_hold det", int'(b_det), 1);
    chk("b_hold cnt", int'(b_cnt), held_cnt);

    // 17 overlapping detections wrap the counter to 1
    async_reset("b_rst_pre_wrap");
    send(7'b0001011, 4, "b_wrap_first");
    for (int i = 0; i < 16; i++) send(7'b0000011, 3, "b_wrap");
    chk("b_wrap cnt", int'(b_cnt), 1);

    // reset after "101": the following '1' must not complete a match
    send(7'b0000101, 3, "b_mid");
    async_reset("b_mid_rst");
    chk("b_mid_rst cnt", int'(b_cnt), 0);
    bstep(1'b1, 1'b1, "b_after_rst");
    chk("b_after_rst det", int'(b_det), 0);
    chk("b_after_rst cnt", int'(b_cnt), 0);

    // random traffic, biased toward '1' so matches are frequent
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset("b_rnd_rst");
      bstep(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 6), "b_rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
